// File: rtl/blackjack_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : blackjack_round_ctrl
// Purpose  : Blackjack round controller. Pulls cards from an upstream card
//            source, deals two cards each to player and dealer, runs the
//            player hit/stand turn and the dealer draw-to-17 turn, then
//            reports both best hand totals and the round result.
// Ports    : clk_i          - system clock, rising edge
//            rst_i          - asynchronous active-low reset
//            start_i        - begin a round (accepted in IDLE or DONE)
//            hit_i/stand_i  - player controls during the player turn
//            card_i         - card code: [3:0] rank, [5:4] suit, [7:6] unused
//            request_card_o - one-cycle request for the next card
//            player_total_o - best player hand value
//            dealer_total_o - best dealer hand value
//            busy_o/done_o  - round in progress / round finished
//            result_o       - 0 none, 1 player, 2 dealer, 3 push
// Revision : 1.0 - initial release
// ============================================================================
module blackjack_round_ctrl #(
  parameter int CARD_LATENCY = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       hit_i,
  input  logic       stand_i,
  input  logic [7:0] card_i,
  output logic       request_card_o,
  output logic [4:0] player_total_o,
  output logic [4:0] dealer_total_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] result_o
);

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_DEAL_REQ     = 4'd1,
    S_DEAL_WAIT    = 4'd2,
    S_PLAYER_TURN  = 4'd3,
    S_HIT_REQ      = 4'd4,
    S_HIT_WAIT     = 4'd5,
    S_DEALER_CHECK = 4'd6,
    S_DEALER_REQ   = 4'd7,
    S_DEALER_WAIT  = 4'd8,
    S_COMPARE      = 4'd9,
    S_DONE         = 4'd10
  } state_t;

  localparam logic [2:0] c_lat_m1 = 3'(CARD_LATENCY - 1);

  state_t     r_state, w_next;
  logic       r_req, w_req_next;
  logic [1:0] r_step;
  logic [2:0] r_wait;
  logic [4:0] r_p_hard, r_d_hard;
  logic       r_p_ace, r_d_ace;
  logic [3:0] r_p_cnt, r_d_cnt;
  logic [1:0] r_result;
  logic       r_natural;
  logic       r_hit_lock;

  logic [3:0] w_rank;
  logic       w_card_ok, w_card_ace;
  logic [4:0] w_card_val;
  logic       w_in_wait, w_sample, w_start;
  logic [4:0] w_p_best, w_d_best;
  logic [4:0] w_p_hard_new;
  logic       w_p_ace_new;
  logic [4:0] w_p_best_new;
  logic [1:0] w_cmp_result;
  logic       w_unused_card_bits;

  // Soft total counts the ace as 11 only when that does not bust the hand.
  function automatic logic [4:0] f_best(input logic [4:0] hard, input logic ace);
    if (ace && (hard <= 5'd11)) f_best = hard + 5'd10;
    else                        f_best = hard;
  endfunction

  assign w_rank             = card_i[3:0];
  assign w_card_ok          = (w_rank >= 4'd1) && (w_rank <= 4'd13);
  assign w_card_ace         = (w_rank == 4'd1);
  assign w_card_val         = (w_rank > 4'd10) ? 5'd10 : {1'b0, w_rank};
  assign w_unused_card_bits = ^card_i[7:4];

  assign w_in_wait = (r_state == S_DEAL_WAIT) || (r_state == S_HIT_WAIT) ||
                     (r_state == S_DEALER_WAIT);
  assign w_sample  = w_in_wait && (r_wait == c_lat_m1);
  assign w_start   = ((r_state == S_IDLE) || (r_state == S_DONE)) && start_i;

  assign w_p_best     = f_best(r_p_hard, r_p_ace);
  assign w_d_best     = f_best(r_d_hard, r_d_ace);
  // Player hand as it will look once the card being sampled is added; the
  // bust / auto-21 decision after a hit is made on this same edge.
  assign w_p_hard_new = r_p_hard + w_card_val;
  assign w_p_ace_new  = r_p_ace | w_card_ace;
  assign w_p_best_new = f_best(w_p_hard_new, w_p_ace_new);

  always_comb begin
    w_cmp_result = 2'd3;
    if (r_natural)                 w_cmp_result = (w_d_best != 5'd21) ? 2'd1 : 2'd3;
    else if (w_d_best > 5'd21)     w_cmp_result = 2'd1;
    else if (w_p_best > w_d_best)  w_cmp_result = 2'd1;
    else if (w_p_best < w_d_best)  w_cmp_result = 2'd2;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start_i) w_next = S_DEAL_REQ;
      S_DEAL_REQ:     w_next = S_DEAL_WAIT;
      S_DEAL_WAIT: begin
        if (w_sample) begin
          if (!w_card_ok)                w_next = S_DEAL_REQ;
          else if (r_step != 2'd3)       w_next = S_DEAL_REQ;
          else if (w_p_best == 5'd21)    w_next = S_COMPARE;
          else                           w_next = S_PLAYER_TURN;
        end
      end
      S_PLAYER_TURN: begin
        if (stand_i)                     w_next = S_DEALER_CHECK;
        else if (hit_i && !r_hit_lock)   w_next = S_HIT_REQ;
      end
      S_HIT_REQ:      w_next = S_HIT_WAIT;
      S_HIT_WAIT: begin
        if (w_sample) begin
          if (!w_card_ok)                w_next = S_HIT_REQ;
          else if (w_p_best_new > 5'd21) w_next = S_DONE;
          else if (w_p_best_new == 5'd21) w_next = S_DEALER_CHECK;
          else                           w_next = S_PLAYER_TURN;
        end
      end
      S_DEALER_CHECK: w_next = (w_d_best < 5'd17) ? S_DEALER_REQ : S_COMPARE;
      S_DEALER_REQ:   w_next = S_DEALER_WAIT;
      S_DEALER_WAIT: begin
        if (w_sample) w_next = w_card_ok ? S_DEALER_CHECK : S_DEALER_REQ;
      end
      S_COMPARE:      w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
    // The request register rises together with entry into a request state,
    // so the pulse occupies exactly the single request-state cycle.
    w_req_next = (w_next == S_DEAL_REQ) || (w_next == S_HIT_REQ) ||
                 (w_next == S_DEALER_REQ);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_req   <= w_req_next;
    end
  end

  // Hand, counter and result datapath.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_step     <= 2'd0;
      r_wait     <= 3'd0;
      r_p_hard   <= 5'd0;
      r_p_ace    <= 1'b0;
      r_p_cnt    <= 4'd0;
      r_d_hard   <= 5'd0;
      r_d_ace    <= 1'b0;
      r_d_cnt    <= 4'd0;
      r_result   <= 2'd0;
      r_natural  <= 1'b0;
      r_hit_lock <= 1'b0;
    end else begin
      r_wait <= (w_in_wait && !w_sample) ? r_wait + 3'd1 : 3'd0;

      // A held hit counts once; the lock clears only when hit_i drops.
      if (!hit_i)
        r_hit_lock <= 1'b0;
      else if ((r_state == S_PLAYER_TURN) && !stand_i)
        r_hit_lock <= 1'b1;

      if (w_start) begin
        r_step    <= 2'd0;
        r_p_hard  <= 5'd0;
        r_p_ace   <= 1'b0;
        r_p_cnt   <= 4'd0;
        r_d_hard  <= 5'd0;
        r_d_ace   <= 1'b0;
        r_d_cnt   <= 4'd0;
        r_result  <= 2'd0;
        r_natural <= 1'b0;
      end else if (w_sample && w_card_ok) begin
        // Even deal steps and all hits go to the player, the rest to the dealer.
        if (((r_state == S_DEAL_WAIT) && !r_step[0]) || (r_state == S_HIT_WAIT)) begin
          r_p_hard <= w_p_hard_new;
          r_p_ace  <= w_p_ace_new;
          r_p_cnt  <= r_p_cnt + 4'd1;
        end else begin
          r_d_hard <= r_d_hard + w_card_val;
          r_d_ace  <= r_d_ace | w_card_ace;
          r_d_cnt  <= r_d_cnt + 4'd1;
        end
        if (r_state == S_DEAL_WAIT) begin
          r_step <= r_step + 2'd1;
          if ((r_step == 2'd3) && (w_p_best == 5'd21)) r_natural <= 1'b1;
        end
        if ((r_state == S_HIT_WAIT) && (w_p_best_new > 5'd21)) r_result <= 2'd2;
      end else if (r_state == S_COMPARE) begin
        r_result <= w_cmp_result;
      end
    end
  end

  assign request_card_o = r_req;
  assign player_total_o = w_p_best;
  assign dealer_total_o = w_d_best;
  assign busy_o         = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done_o         = (r_state == S_DONE);
  assign result_o       = r_result;

endmodule
`default_nettype wire

// File: tb/tb_blackjack_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_blackjack_round_ctrl
// Purpose  : Self-checking bench for blackjack_round_ctrl. Two instances are
//            used, one with CARD_LATENCY = 1 and one with CARD_LATENCY = 3,
//            each fed by a card-source model that presents a card only in
//            the cycle it must be sampled (0x0F otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module tb_blackjack_round_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start1 = 1'b0, start3 = 1'b0;
  logic       hit = 1'b0, stand = 1'b0;
  logic [7:0] card1 = 8'h0F, card3 = 8'h0F;
  logic       req1, req3, busy1, busy3, done1, done3;
  logic [4:0] pt1, dt1, pt3, dt3;
  logic [1:0] res1, res3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  blackjack_round_ctrl #(.CARD_LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start1), .hit_i(hit), .stand_i(stand),
    .card_i(card1), .request_card_o(req1), .player_total_o(pt1),
    .dealer_total_o(dt1), .busy_o(busy1), .done_o(done1), .result_o(res1));

  blackjack_round_ctrl #(.CARD_LATENCY(3)) dut3 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start3), .hit_i(hit), .stand_i(stand),
    .card_i(card3), .request_card_o(req3), .player_total_o(pt3),
    .dealer_total_o(dt3), .busy_o(busy3), .done_o(done3), .result_o(res3));

  // Card source models: a request seen in cycle c puts the card on the bus
  // for cycle c+LATENCY only.
  logic [7:0] q1[$], q3[$];
  int         st1[$], st3[$];
  logic [7:0] pend1, pend3;
  int         cd1 = 0, cd3 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cd1 = 0; card1 = 8'h0F;
    end else begin
      if (cd1 > 0) begin cd1--; card1 = (cd1 == 0) ? pend1 : 8'h0F; end
      else card1 = 8'h0F;
      if (req1) begin
        st1.push_back(cyc);
        pend1 = (q1.size() > 0) ? q1.pop_front() : 8'h02;
        cd1 = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      cd3 = 0; card3 = 8'h0F;
    end else begin
      if (cd3 > 0) begin cd3--; card3 = (cd3 == 0) ? pend3 : 8'h0F; end
      else card3 = 8'h0F;
      if (req3) begin
        st3.push_back(cyc);
        pend3 = (q3.size() > 0) ? q3.pop_front() : 8'h02;
        cd3 = 3;
      end
    end
  end

  typedef struct {
    logic [63:0] cards;   // card k in bits [8k+7:8k]
    int          nc;
    int          nhits;
    int          hold;    // cycles hit_i is held per hit
    bit          do_stand;
    int          ep, ed, er, epulse;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [63:0] pk(input logic [7:0] a, b, c, d, e, f);
    pk = {16'h0, f, e, d, c, b, a};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done1(input string nm);
    int k;
    for (k = 0; k < 200 && !done1; k++) tick(1);
    if (!done1) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic run_round(input int i);
    int s;
    q1.delete(); st1.delete();
    for (int k = 0; k < vecs[i].nc; k++) q1.push_back(vecs[i].cards[8*k +: 8]);
    s = cyc; start1 = 1'b1; tick(1); start1 = 1'b0;
    chk($sformatf("v%0d_busy_after_start", i), int'(busy1), 1);
    tick(13);
    if (vecs[i].do_stand || vecs[i].nhits > 0) begin
      // start while busy must be ignored
      start1 = 1'b1; tick(1); start1 = 1'b0; tick(1);
    end
    for (int h = 0; h < vecs[i].nhits; h++) begin
      hit = 1'b1; tick(vecs[i].hold); hit = 1'b0; tick(6);
    end
    if (vecs[i].do_stand) begin stand = 1'b1; tick(1); stand = 1'b0; end
    wait_done1($sformatf("v%0d", i));
    tick(2);
    chk($sformatf("v%0d_player", i), int'(pt1), vecs[i].ep);
    chk($sformatf("v%0d_dealer", i), int'(dt1), vecs[i].ed);
    chk($sformatf("v%0d_result", i), int'(res1), vecs[i].er);
    chk($sformatf("v%0d_pulses", i), st1.size(), vecs[i].epulse);
    chk($sformatf("v%0d_done", i), int'(done1), 1);
    chk($sformatf("v%0d_busy_end", i), int'(busy1), 0);
    chk($sformatf("v%0d_first_req", i), (st1.size() > 0) ? st1[0] : -1, s + 1);
  endtask

  initial begin
    int k, s;
    //          cards                                           nc hit hold st  p   d   r  pulses
    vecs[0]  = '{pk(8'h0A,8'h05,8'h01,8'h06,8'h00,8'h00),     4, 0, 0,  0, 21, 11, 1, 4}; // natural
    vecs[1]  = '{pk(8'h07,8'h09,8'h08,8'h07,8'h0D,8'h00),     5, 1, 2,  0, 25, 16, 2, 5}; // bust
    vecs[2]  = '{pk(8'h0A,8'h01,8'h09,8'h06,8'h00,8'h00),     4, 0, 0,  1, 19, 17, 1, 4}; // soft 17
    vecs[3]  = '{pk(8'h0A,8'h02,8'h08,8'h04,8'h0C,8'h02),     6, 0, 0,  1, 18, 18, 3, 6}; // push
    vecs[4]  = '{pk(8'h02,8'h0A,8'h03,8'h07,8'h04,8'h00),     5, 1, 12, 1,  9, 17, 2, 5}; // held hit
    vecs[5]  = '{pk(8'h05,8'h0A,8'h06,8'h08,8'h0A,8'h00),     5, 1, 2,  0, 21, 18, 1, 5}; // hit to 21
    vecs[6]  = '{pk(8'h0A,8'h06,8'h07,8'h0A,8'h09,8'h00),     5, 0, 0,  1, 17, 25, 1, 5}; // dealer bust
    vecs[7]  = '{pk(8'h01,8'h0A,8'h0B,8'h01,8'h00,8'h00),     4, 0, 0,  0, 21, 21, 3, 4}; // both naturals
    vecs[8]  = '{pk(8'h09,8'h0A,8'h07,8'h09,8'h00,8'h00),     4, 0, 0,  1, 16, 19, 2, 4}; // player low
    vecs[9]  = '{pk(8'h0E,8'h03,8'h05,8'h04,8'h06,8'h0A),     6, 0, 0,  1,  7, 21, 2, 6}; // invalid card
    vecs[10] = '{pk(8'h01,8'h05,8'h01,8'h06,8'h09,8'h0D),     6, 1, 2,  0, 21, 21, 3, 6}; // soft hit push

    // Reset state
    tick(3);
    chk("rst_req", int'(req1), 0);
    chk("rst_player", int'(pt1), 0);
    chk("rst_dealer", int'(dt1), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_done", int'(done1), 0);
    chk("rst_result", int'(res1), 0);
    rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < 11; i++) begin
      run_round(i);
      if (i == 9) chk("v9_retry_gap", (st1.size() > 1) ? st1[1] - st1[0] : -1, 2);
    end

    // Asynchronous reset while in DONE with a result held
    #2 rst_n = 1'b0; #1;
    chk("rst_done_async_done", int'(done1), 0);
    chk("rst_done_async_result", int'(res1), 0);
    chk("rst_done_async_player", int'(pt1), 0);
    tick(2); rst_n = 1'b1; tick(1);

    // Reset in the middle of DEAL_WAIT for the third card
    q1.delete(); st1.delete();
    for (int j = 0; j < 4; j++) q1.push_back(vecs[0].cards[8*j +: 8]);
    start1 = 1'b1; tick(1); start1 = 1'b0;
    for (k = 0; k < 50 && st1.size() < 3; k++) tick(1);
    chk("mid_player_before", int'(pt1), 10);
    chk("mid_dealer_before", int'(dt1), 5);
    rst_n = 1'b0; #1;
    chk("mid_busy", int'(busy1), 0);
    chk("mid_req", int'(req1), 0);
    chk("mid_player", int'(pt1), 0);
    chk("mid_dealer", int'(dt1), 0);
    tick(2);
    q1.delete();
    rst_n = 1'b1;
    tick(4);
    chk("mid_no_stale_req", st1.size(), 3);
    chk("mid_idle_player", int'(pt1), 0);
    run_round(0);

    // Invalid first card with CARD_LATENCY = 3
    q3.delete(); st3.delete();
    q3.push_back(8'h0E); q3.push_back(8'h03); q3.push_back(8'h05);
    q3.push_back(8'h04); q3.push_back(8'h06); q3.push_back(8'h0A);
    s = cyc; start3 = 1'b1; tick(1); start3 = 1'b0;
    tick(26);
    chk("l3_first_req", (st3.size() > 0) ? st3[0] : -1, s + 1);
    chk("l3_retry_gap", (st3.size() > 1) ? st3[1] - st3[0] : -1, 4);
    chk("l3_deal_gap", (st3.size() > 2) ? st3[2] - st3[1] : -1, 4);
    chk("l3_deal_pulses", st3.size(), 5);
    chk("l3_player", int'(pt3), 7);
    chk("l3_dealer", int'(dt3), 11);
    chk("l3_busy", int'(busy3), 1);
    stand = 1'b1; tick(1); stand = 1'b0;
    for (k = 0; k < 200 && !done3; k++) tick(1);
    if (!done3) chk("l3_timeout", 0, 1);
    chk("l3_result", int'(res3), 2);
    chk("l3_dealer_final", int'(dt3), 21);
    chk("l3_pulses", st3.size(), 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/blackjack_round_ctrl.md
# blackjack_round_ctrl

Round controller for the blackjack game, directly downstream of the seed-random card source. It requests cards one at a time over `request_card_o`/`card_i` and deals two cards each to player and dealer. It then runs the player hit/stand turn and the dealer draw-to-17 turn, and reports both hand totals and the round result.

## Interface
- CARD_LATENCY, default 1: clock cycles from the `request_card_o` cycle to the cycle `card_i` is sampled (legal values 1–7).
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  level; begins a round when sampled high in IDLE or DONE.
- hit_i  in  1  level; player requests a card during PLAYER_TURN.
- stand_i  in  1  level; player ends turn during PLAYER_TURN.
- card_i  in  8  card code from the card source: [3:0] rank, [5:4] suit, [7:6] ignored.
- request_card_o  out  1  one-cycle pulse requesting the next card.
- player_total_o  out  5  best player hand value.
- dealer_total_o  out  5  best dealer hand value.
- busy_o  out  1  high in every state except IDLE and DONE.
- done_o  out  1  high in DONE.
- result_o  out  2  0 none, 1 player wins, 2 dealer wins, 3 push.

## Operation
- Rank decode:
  - rank 1 is Ace (value 1, sets an ace flag);
  - ranks 2–10 are face value;
  - ranks 11–13 are 10;
  - ranks 0, 14 and 15 are invalid. The card is discarded and the same deal step re-issues a request.
- Each hand keeps a 5-bit hard sum, an ace flag and a card count. Best value = hard + 10 if the ace flag is set and hard + 10 ≤ 21; otherwise best value = hard. Max hard sum is 30, so it fits 5 bits.
- States: IDLE, DEAL_REQ, DEAL_WAIT, PLAYER_TURN, HIT_REQ, HIT_WAIT, DEALER_CHECK, DEALER_REQ, DEALER_WAIT, COMPARE, DONE.
- IDLE/DONE + start_i:
  - clear both hands and result_o;
  - deal step = 0;
  - go to DEAL_REQ.
- Deal order is player, dealer, player, dealer (steps 0–3). DEAL_REQ pulses the request. DEAL_WAIT counts CARD_LATENCY cycles, then samples card_i into the hand selected by step.
- After step 3:
  - player best == 21 → COMPARE (natural; the dealer does not draw);
  - otherwise → PLAYER_TURN.
- PLAYER_TURN:
  - stand_i → DEALER_CHECK; stand takes priority over a simultaneous hit_i;
  - hit_i → HIT_REQ → HIT_WAIT, then add the card to the player hand;
  - after a hit, player best > 21 → DONE with result 2 (bust; the dealer does not draw);
  - after a hit, player best == 21 → DEALER_CHECK automatically;
  - otherwise return to PLAYER_TURN. hit_i must drop and be re-asserted for a further hit; a held hit_i is a single hit.
- DEALER_CHECK:
  - dealer best < 17 → DEALER_REQ → DEALER_WAIT → add card → DEALER_CHECK;
  - dealer best ≥ 17 → COMPARE. The dealer stands on soft 17.
- COMPARE, resolved in order:
  - player natural and dealer best ≠ 21 → 1;
  - player natural and dealer best = 21 → 3;
  - dealer best > 21 → 1;
  - player > dealer → 1;
  - player < dealer → 2;
  - equal → 3.
  - Then go to DONE.
- DONE holds totals and result until start_i. start_i while busy is ignored.

## Timing
- Reset (rst_i low, any state, including mid-deal or mid-wait):
  - immediate return to IDLE;
  - all outputs 0: request_card_o, totals, busy_o, done_o, result_o;
  - no pending request survives. A card arriving after reset is ignored.
- request_card_o is registered and high for exactly one cycle per card. A new request is never issued before the previous card is sampled.
- A card is sampled on the edge CARD_LATENCY cycles after the request-pulse cycle. Totals update on the cycle after sampling.
- Invalid-card retry: a new request is issued 1 cycle after the discard.
- start_i to first request_card_o: 1 cycle. done_o and result_o assert 1 cycle after COMPARE (or after the bust sample).
- busy_o asserts the cycle after start_i is accepted.

## Test plan
- Natural: cards 0x0A, 0x05, 0x01, 0x06.
  - Expect player_total 21, dealer_total 11, result 1, exactly 4 request pulses.
- Player bust:
  - Deal 0x07, 0x09, 0x08, 0x07, then hit with 0x0D.
  - Expect player_total 25, dealer_total 16, result 2, 5 pulses, no dealer draw.
- Soft 17:
  - Deal 0x0A, 0x01, 0x09, 0x06, then stand.
  - Expect dealer_total 17 with no draw, player_total 19, result 1.
- Push with dealer draw:
  - Deal 0x0A, 0x02, 0x08, 0x04, then stand. Dealer draws 0x0C.
  - Expect dealer_total 16, then 0x02 brings it to 18; result 3, 6 pulses.
- Invalid card:
  - First card 0x0E, then 0x03.
  - Expect 0x0E discarded, an extra request 1 cycle later, player hand 3. Repeat with CARD_LATENCY = 3.
- Reset mid-DEAL_WAIT:
  - Pull rst_i low.
  - Expect all outputs 0 asynchronously; after release, a fresh start_i deals from step 0.
